bf_twiddle_stage: RTL and testbench

- Radix-2 MDC FFT butterfly and twiddle-multiply stage.
- Consumes the dual-stream pair (x0, x1, valid) produced by the delay-commutator chain.
- Emits the scaled sum on y0 and the twiddle-rotated, scaled difference on y1.
- Generates the twiddle ROM address from an internal sample counter. The ROM itself is external, with 1-cycle registered read.

---
 rtl/bf_twiddle_stage.sv | 146 ++++++++++++++
 tb/tb_bf_twiddle_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bf_twiddle_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bf_twiddle_stage
// Purpose  : Radix-2 MDC FFT butterfly with twiddle rotation of the lower leg.
// Revision : 1.0 - initial release
// ============================================================================
module bf_twiddle_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 32,
  parameter int STAGE      = 0,
  parameter int TW_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   x0,
  input  logic [DATA_WIDTH-1:0]   x1,
  input  logic                    in_valid,
  output logic [$clog2(N)-2:0]    tw_addr,
  input  logic [TW_WIDTH-1:0]     tw_re,
  input  logic [TW_WIDTH-1:0]     tw_im,
  output logic [DATA_WIDTH-1:0]   y0,
  output logic [DATA_WIDTH-1:0]   y1,
  output logic                    out_valid,
  output logic                    out_last
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int AW = $clog2(N) - 1;
  localparam int PW = HW + TW_WIDTH + 1;

  localparam logic [AW-1:0]        CNT_LAST   = AW'(N / 2 - 1);
  localparam logic [AW-1:0]        ADDR_MASK  = AW'((N >> (STAGE + 1)) - 1);
  localparam logic signed [PW-1:0] ROUND_BIAS = PW'(2 ** (TW_WIDTH - 2));
  localparam logic signed [PW-1:0] SAT_MAX    = PW'(2 ** (HW - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN    = ~SAT_MAX;

  // Halved sum/difference at HW+1 bits; the shift guarantees the result fits HW bits.
  function automatic logic [HW-1:0] half_op(input logic signed [HW-1:0] p,
                                            input logic signed [HW-1:0] q,
                                            input logic sub);
    logic signed [HW:0] t;
    t = sub ? ((HW+1)'(p) - (HW+1)'(q)) : ((HW+1)'(p) + (HW+1)'(q));
    half_op = HW'(t >>> 1);
  endfunction

  function automatic logic [HW-1:0] round_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] r;
    r = (v + ROUND_BIAS) >>> (TW_WIDTH - 1);
    if (r > SAT_MAX)
      round_sat = SAT_MAX[HW-1:0];
    else if (r < SAT_MIN)
      round_sat = SAT_MIN[HW-1:0];
    else
      round_sat = r[HW-1:0];
  endfunction

  logic [AW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic                  vld1_q, vld1_d;
  logic                  last1_q, last1_d;
  logic                  kz_q, kz_d;
  logic [DATA_WIDTH-1:0] y0_q, y0_d;
  logic [DATA_WIDTH-1:0] y1_q, y1_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic signed [HW-1:0]       a_re, a_im, b_re, b_im;
  logic signed [HW-1:0]       dr, di;
  logic signed [TW_WIDTH-1:0] w_re, w_im;
  logic signed [PW-1:0]       prod_re, prod_im;

  assign a_re = x0[DATA_WIDTH-1:HW];
  assign a_im = x0[HW-1:0];
  assign b_re = x1[DATA_WIDTH-1:HW];
  assign b_im = x1[HW-1:0];
  assign dr   = diff_q[DATA_WIDTH-1:HW];
  assign di   = diff_q[HW-1:0];
  assign w_re = tw_re;
  assign w_im = tw_im;

  // The ROM word for this address is on tw_re/tw_im when the diff reaches stage 2.
  assign tw_addr = (cnt_q & ADDR_MASK) << STAGE;

  assign prod_re = PW'(dr) * PW'(w_re) - PW'(di) * PW'(w_im);
  assign prod_im = PW'(dr) * PW'(w_im) + PW'(di) * PW'(w_re);

  always_comb begin
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    diff_d      = diff_q;
    vld1_d      = in_valid;
    last1_d     = in_valid & (cnt_q == CNT_LAST);
    kz_d        = (tw_addr == '0);
    y0_d        = y0_q;
    y1_d        = y1_q;
    out_valid_d = vld1_q;
    out_last_d  = vld1_q & last1_q;

    if (in_valid) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + AW'(1);
      sum_d  = {half_op(a_re, b_re, 1'b0), half_op(a_im, b_im, 1'b0)};
      diff_d = {half_op(a_re, b_re, 1'b1), half_op(a_im, b_im, 1'b1)};
    end

    // W^0 is exactly 1, so the multiplier is bypassed to avoid Q1.15 rounding loss.
    if (vld1_q) begin
      y0_d = sum_q;
      y1_d = kz_q ? diff_q : {round_sat(prod_re), round_sat(prod_im)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      sum_q       <= '0;
      diff_q      <= '0;
      vld1_q      <= 1'b0;
      last1_q     <= 1'b0;
      kz_q        <= 1'b0;
      y0_q        <= '0;
      y1_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      diff_q      <= diff_d;
      vld1_q      <= vld1_d;
      last1_q     <= last1_d;
      kz_q        <= kz_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign y0        = y0_q;
  assign y1        = y1_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_bf_twiddle_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bf_twiddle_stage
// Purpose  : Scoreboard bench for two butterfly instances (STAGE 0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_twiddle_stage;

  localparam int DW = 16;
  localparam int N  = 32;
  localparam int TW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] x0 = '0, x1 = '0;
  logic          in_valid = 1'b0;

  logic [AW-1:0] tw_addr0, tw_addr1;
  logic [TW-1:0] tw_re0, tw_im0, tw_re1, tw_im1;
  logic [DW-1:0] y0_0, y1_0, y0_1, y1_1;
  logic          ov0, ol0, ov1, ol1;

  always #5 clk = ~clk;

  bf_twiddle_stage #(.DATA_WIDTH(DW), .N(N), .STAGE(0), .TW_WIDTH(TW)) u_s0 (
    .clk(clk), .reset(reset), .x0(x0), .x1(x1), .in_valid(in_valid),
    .tw_addr(tw_addr0), .tw_re(tw_re0), .tw_im(tw_im0),
    .y0(y0_0), .y1(y1_0), .out_valid(ov0), .out_last(ol0));

  bf_twiddle_stage #(.DATA_WIDTH(DW), .N(N), .STAGE(1), .TW_WIDTH(TW)) u_s1 (
    .clk(clk), .reset(reset), .x0(x0), .x1(x1), .in_valid(in_valid),
    .tw_addr(tw_addr1), .tw_re(tw_re1), .tw_im(tw_im1),
    .y0(y0_1), .y1(y1_1), .out_valid(ov1), .out_last(ol1));

  // Twiddle ROM with registered read
  logic [TW-1:0] cos_tab [N/2];
  logic [TW-1:0] msin_tab[N/2];

  initial begin
    for (int k = 0; k < N/2; k++) begin
      real ang;
      int  vc, vs;
      ang = 2.0 * 3.14159265358979 * k / N;
      vc  = int'($cos(ang) * 32768.0);
      vs  = int'(-$sin(ang) * 32768.0);
      if (vc > 32767) vc = 32767;
      if (vs > 32767) vs = 32767;
      cos_tab[k]  = 16'(vc);
      msin_tab[k] = 16'(vs);
    end
  end

  always @(posedge clk) begin
    tw_re0 <= cos_tab[tw_addr0];
    tw_im0 <= msin_tab[tw_addr0];
    tw_re1 <= cos_tab[tw_addr1];
    tw_im1 <= msin_tab[tw_addr1];
  end

  typedef struct {
    logic [DW-1:0] y0;
    logic [DW-1:0] y1;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] hold_y0[2];
  logic [DW-1:0] hold_y1[2];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            cnt_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] cpx(input int re, input int im);
    return {8'(re), 8'(im)};
  endfunction

  task automatic mon(input int inst, input logic ov, input logic ol,
                     input logic [DW-1:0] y0, input logic [DW-1:0] y1);
    exp_t  e;
    bit    empty;
    string p;
    p     = (inst == 0) ? "s0" : "s1";
    empty = 1'b0;
    if (ov === 1'b1) begin
      if (inst == 0) begin
        if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
      end else begin
        if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
      end
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_valid: got out_valid 1, expected 0 at cycle %0d", p, cyc);
      end else begin
        chk({p, "_y0"}, 32'(y0), 32'(e.y0));
        chk({p, "_y1"}, 32'(y1), 32'(e.y1));
        chk({p, "_last"}, 32'(ol), 32'(e.last));
        chk({p, "_latency_cycle"}, cyc, e.cyc);
        hold_y0[inst] = e.y0;
        hold_y1[inst] = e.y1;
      end
    end else begin
      chk({p, "_out_valid_idle"}, 32'(ov), 32'(0));
      chk({p, "_out_last_idle"}, 32'(ol), 32'(0));
      chk({p, "_y0_hold"}, 32'(y0), 32'(hold_y0[inst]));
      chk({p, "_y1_hold"}, 32'(y1), 32'(hold_y1[inst]));
    end
  endtask

  initial begin
    hold_y0[0] = '0; hold_y0[1] = '0;
    hold_y1[0] = '0; hold_y1[1] = '0;
  end

  always @(negedge clk) begin
    mon(0, ov0, ol0, y0_0, y1_0);
    mon(1, ov1, ol1, y0_1, y1_1);
  end

  // One input cycle; checks the address seen before the drive, queues expectations.
  task automatic send(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] ey0, input logic [DW-1:0] ey1_s0,
                      input logic [DW-1:0] ey1_s1);
    exp_t e;
    @(posedge clk);
    #1;
    chk("s0_tw_addr", 32'(tw_addr0), cnt_m);
    chk("s1_tw_addr", 32'(tw_addr1), (cnt_m % 8) * 2);
    in_valid = v;
    x0       = a;
    x1       = b;
    if (v) begin
      e.y0   = ey0;
      e.last = (cnt_m == N/2 - 1);
      e.cyc  = cyc + 2;
      e.y1   = ey1_s0;
      q0.push_back(e);
      e.y1   = ey1_s1;
      q1.push_back(e);
      cnt_m  = (cnt_m + 1) % (N/2);
    end
  endtask

  // a == b gives sum = a and diff = 0, so y1 = 0 for any twiddle
  task automatic fill(input int v);
    send(1'b1, cpx(v, -v), cpx(v, -v), cpx(v, -v), '0, '0);
  endtask

  task automatic idle();
    send(1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_s0_out_valid"}, 32'(ov0), 0);
    chk({tag, "_s0_out_last"}, 32'(ol0), 0);
    chk({tag, "_s0_y0"}, 32'(y0_0), 0);
    chk({tag, "_s0_y1"}, 32'(y1_0), 0);
    chk({tag, "_s0_tw_addr"}, 32'(tw_addr0), 0);
    chk({tag, "_s1_out_valid"}, 32'(ov1), 0);
    chk({tag, "_s1_y1"}, 32'(y1_1), 0);
    chk({tag, "_s1_tw_addr"}, 32'(tw_addr1), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_state("reset");
    reset = 1'b1;

    // Frame 1: k=0 bypass, saturation at cnt 4, -j rotation at cnt 8, gaps
    send(1'b1, cpx(10, 4), cpx(2, -6), cpx(6, -1), cpx(4, 5), cpx(4, 5));
    for (int i = 1; i <= 3; i++) fill(i);
    send(1'b1, cpx(127, 127), cpx(-128, -128), cpx(-1, -1), cpx(127, 0), cpx(127, -127));
    for (int i = 5; i <= 7; i++) fill(i);
    send(1'b1, cpx(10, 4), cpx(2, -6), cpx(6, -1), cpx(5, -4), cpx(4, 5));
    fill(9);
    idle();
    idle();
    fill(10);
    fill(11);
    for (int i = 12; i <= 15; i++) fill(i);

    // Frame 2: wraps to address 0, then reset with pairs still in the pipeline
    for (int i = 0; i < 5; i++) fill(20 + i);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    hold_y0[0] = '0; hold_y0[1] = '0;
    hold_y1[0] = '0; hold_y1[1] = '0;
    cnt_m = 0;
    check_zero_state("midreset");

    // Frame 3: fresh frame after reset, out_last on the 16th output
    for (int i = 0; i < 16; i++) fill(30 + i);
    repeat (4) idle();

    chk("s0_queue_drained", q0.size(), 0);
    chk("s1_queue_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
